alu_vec_pipe: RTL

- Parametrised, registered successor to the combinational vector ALU.
- Applies one 4-bit operation across LANES lanes of WIDTH-bit operands, with per-lane NZCV flags.
- Adds valid/ready handshakes on both sides, a registered output, a per-lane enable mask, saturating and min/max ops, and a multi-cycle cross-lane reduction.
- Sits between the vector register-file read stage and vector writeback.

---
 rtl/alu_vec_pkg.sv | 43 ++++
 rtl/alu_vec_lane.sv | 110 +++++++++++
 rtl/alu_vec_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_vec_pkg.sv
// ----------------------------------------------------------------------------
// alu_vec_pkg
// Shared types for the pipelined vector ALU: operation codes, NZCV flag bit
// positions, reduction FSM states and a signed-overflow helper.
// ----------------------------------------------------------------------------
package alu_vec_pkg;

   typedef enum logic [3:0] {
      ADD    = 4'd0,
      SUB    = 4'd1,
      AND    = 4'd2,
      OR     = 4'd3,
      XOR    = 4'd4,
      SHL    = 4'd5,
      SHR    = 4'd6,
      ADDS   = 4'd7,
      SUBS   = 4'd8,
      MIN    = 4'd9,
      MAX    = 4'd10,
      REDSUM = 4'd11
   } vec_op_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RED  = 1'b1
   } vec_state_e;

   // Two's complement overflow of a + b, from the operand and sum sign bits.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // Two's complement overflow of a - b.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_vec_lane.sv
// ----------------------------------------------------------------------------
// alu_vec_lane
// Purely combinational single-lane ALU slice with NZCV flag generation.
// Ports:
//   i_op      operation code (REDSUM and reserved codes give result 0, flags 0)
//   i_en      lane enable; a disabled lane passes i_a through with flags 0000
//   i_a, i_b  lane operands
//   o_result  lane result
//   o_nzcv    lane flags {N, Z, C, V}
// ----------------------------------------------------------------------------
module alu_vec_lane
   import alu_vec_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  vec_op_e            i_op,
   input  logic               i_en,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [WIDTH-1:0]   o_result,
   output logic [3:0]         o_nzcv
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_add_v;
   logic             w_sub_v;
   logic [SHW-1:0]   w_amt;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic             w_lt;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_valid_op;

   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
   assign w_add_v = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1]);
   assign w_sub_v = sub_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_diff[WIDTH-1]);
   assign w_amt   = i_b[SHW-1:0];
   // One guard bit on each side catches the last bit shifted out; it is 0 for amount 0.
   assign w_shl   = {1'b0, i_a} << w_amt;
   assign w_shr   = {i_a, 1'b0} >> w_amt;
   assign w_lt    = $signed(i_a) < $signed(i_b);

   always_comb begin
      w_res      = '0;
      w_c        = 1'b0;
      w_v        = 1'b0;
      w_valid_op = 1'b1;
      case (i_op)
         ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_add_v;
         end
         SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = ~w_diff[WIDTH];
            w_v   = w_sub_v;
         end
         AND: w_res = i_a & i_b;
         OR:  w_res = i_a | i_b;
         XOR: w_res = i_a ^ i_b;
         SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         ADDS: begin
            w_res = w_add_v ? (i_a[WIDTH-1] ? SMIN : SMAX) : w_sum[WIDTH-1:0];
            w_v   = w_add_v;
         end
         SUBS: begin
            w_res = w_sub_v ? (i_a[WIDTH-1] ? SMIN : SMAX) : w_diff[WIDTH-1:0];
            w_v   = w_sub_v;
         end
         MIN: w_res = w_lt ? i_a : i_b;
         MAX: w_res = w_lt ? i_b : i_a;
         default: w_valid_op = 1'b0;
      endcase
   end

   always_comb begin
      o_result = '0;
      o_nzcv   = '0;
      if (!w_valid_op) begin
         // Reserved codes zero every lane regardless of the mask.
         o_result = '0;
         o_nzcv   = '0;
      end else if (!i_en) begin
         o_result = i_a;
      end else begin
         o_result       = w_res;
         o_nzcv[FLAG_N] = w_res[WIDTH-1];
         o_nzcv[FLAG_Z] = (w_res == '0);
         o_nzcv[FLAG_C] = w_c;
         o_nzcv[FLAG_V] = w_v;
      end
   end

endmodule

// File: rtl/alu_vec_pipe.sv
// ----------------------------------------------------------------------------
// alu_vec_pipe
// Registered LANES x WIDTH vector ALU with valid/ready on both sides, per-lane
// enable mask and a multi-cycle cross-lane sum (REDSUM).
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   i_in_valid     operand bundle valid
//   o_in_ready     bundle can be accepted this cycle (combinational on i_out_ready)
//   i_alu_ctrl     operation code (vec_op_e)
//   i_lane_en      per-lane enable mask
//   i_a, i_b       packed operands, lane i = i_a[i]
//   o_out_valid    result register holds a result
//   i_out_ready    consumer takes the result
//   o_result       per-lane result
//   o_nzcv         per-lane flags {N, Z, C, V}
//   o_busy         reduction in progress
// ----------------------------------------------------------------------------
module alu_vec_pipe
   import alu_vec_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANES = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [3:0]                   i_alu_ctrl,
   input  logic [LANES-1:0]             i_lane_en,
   input  logic [LANES-1:0][WIDTH-1:0]  i_a,
   input  logic [LANES-1:0][WIDTH-1:0]  i_b,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [LANES-1:0][WIDTH-1:0]  o_result,
   output logic [LANES-1:0][3:0]        o_nzcv,
   output logic                         o_busy
);

   localparam int unsigned IDXW = $clog2(LANES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

   vec_op_e                      w_op;
   logic                         w_accept;
   logic [LANES-1:0][WIDTH-1:0]  w_lane_result;
   logic [LANES-1:0][3:0]        w_lane_nzcv;

   vec_state_e                   r_state, w_state_nxt;
   logic                         r_out_valid, w_out_valid_nxt;
   logic [LANES-1:0][WIDTH-1:0]  r_result, w_result_nxt;
   logic [LANES-1:0][3:0]        r_nzcv, w_nzcv_nxt;
   logic [WIDTH-1:0]             r_acc, w_acc_nxt;
   logic                         r_c, w_c_nxt;
   logic                         r_v, w_v_nxt;
   logic [IDXW-1:0]              r_idx, w_idx_nxt;
   logic [LANES-1:0][WIDTH-1:0]  r_red_a, w_red_a_nxt;
   logic [LANES-1:0]             r_red_en, w_red_en_nxt;

   logic [WIDTH-1:0]             w_addend;
   logic [WIDTH:0]               w_red_sum;
   logic                         w_red_c;
   logic                         w_red_v;

   assign w_op        = vec_op_e'(i_alu_ctrl);
   assign o_in_ready  = (r_state == IDLE) && (!r_out_valid || i_out_ready);
   assign w_accept    = i_in_valid && o_in_ready;
   assign o_busy      = (r_state == RED);
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_nzcv      = r_nzcv;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      alu_vec_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .i_op     (w_op),
         .i_en     (i_lane_en[g]),
         .i_a      (i_a[g]),
         .i_b      (i_b[g]),
         .o_result (w_lane_result[g]),
         .o_nzcv   (w_lane_nzcv[g])
      );
   end

   // One reduction step: masked lanes contribute zero, so they cannot set C or V.
   assign w_addend  = r_red_en[r_idx] ? r_red_a[r_idx] : '0;
   assign w_red_sum = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_red_c   = r_c | w_red_sum[WIDTH];
   assign w_red_v   = r_v | add_ovf(r_acc[WIDTH-1], w_addend[WIDTH-1], w_red_sum[WIDTH-1]);

   always_comb begin
      w_state_nxt     = r_state;
      w_out_valid_nxt = r_out_valid & ~i_out_ready;
      w_result_nxt    = r_result;
      w_nzcv_nxt      = r_nzcv;
      w_acc_nxt       = r_acc;
      w_c_nxt         = r_c;
      w_v_nxt         = r_v;
      w_idx_nxt       = r_idx;
      w_red_a_nxt     = r_red_a;
      w_red_en_nxt    = r_red_en;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_op == REDSUM) begin
                  w_red_a_nxt  = i_a;
                  w_red_en_nxt = i_lane_en;
                  w_acc_nxt    = '0;
                  w_c_nxt      = 1'b0;
                  w_v_nxt      = 1'b0;
                  w_idx_nxt    = '0;
                  w_state_nxt  = RED;
               end else begin
                  w_out_valid_nxt = 1'b1;
                  w_result_nxt    = w_lane_result;
                  w_nzcv_nxt      = w_lane_nzcv;
               end
            end
         end
         RED: begin
            w_acc_nxt = w_red_sum[WIDTH-1:0];
            w_c_nxt   = w_red_c;
            w_v_nxt   = w_red_v;
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               // Output register is empty here: entry to RED required a drain.
               w_out_valid_nxt           = 1'b1;
               w_result_nxt              = '0;
               w_result_nxt[0]           = w_red_sum[WIDTH-1:0];
               w_nzcv_nxt                = '0;
               w_nzcv_nxt[0][FLAG_N]     = w_red_sum[WIDTH-1];
               w_nzcv_nxt[0][FLAG_Z]     = (w_red_sum[WIDTH-1:0] == '0);
               w_nzcv_nxt[0][FLAG_C]     = w_red_c;
               w_nzcv_nxt[0][FLAG_V]     = w_red_v;
               w_idx_nxt                 = '0;
               w_state_nxt               = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_nzcv      <= '0;
         r_acc       <= '0;
         r_c         <= 1'b0;
         r_v         <= 1'b0;
         r_idx       <= '0;
         r_red_a     <= '0;
         r_red_en    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_result    <= w_result_nxt;
         r_nzcv      <= w_nzcv_nxt;
         r_acc       <= w_acc_nxt;
         r_c         <= w_c_nxt;
         r_v         <= w_v_nxt;
         r_idx       <= w_idx_nxt;
         r_red_a     <= w_red_a_nxt;
         r_red_en    <= w_red_en_nxt;
      end
   end

endmodule
